ddr3_master_wr: RTL

DDR3_MASTER_WR -- requirements
Module: ddr3_master_wr

---
 rtl/ddr3_master_wr_if.sv | 28 ++
 rtl/ddr3_master_wr.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_master_wr_if.sv
// ddr3_master_wr_if
// Bundles the JPEG byte stream and the DDR3 word-write channel used by
// ddr3_master_wr.
//   i_jpeg_byte / i_jpeg_vld / i_jpeg_eof : encoder byte stream into the writer
//   o_jpeg_ready                          : writer accepts a byte this cycle
//   o_jpeg_wr_req / _addr / _data         : level write request, held until done
//   i_jpeg_wr_down                        : single-cycle write-complete pulse
// Modport master is the writer side; modport slave is the encoder/DDR side.
interface ddr3_master_wr_if;
    logic [7:0]   i_jpeg_byte;
    logic         i_jpeg_vld;
    logic         i_jpeg_eof;
    logic         o_jpeg_ready;
    logic         o_jpeg_wr_req;
    logic [23:0]  o_jpeg_wr_addr;
    logic [127:0] o_jpeg_wr_data;
    logic         i_jpeg_wr_down;

    modport master (
        input  i_jpeg_byte, i_jpeg_vld, i_jpeg_eof, i_jpeg_wr_down,
        output o_jpeg_ready, o_jpeg_wr_req, o_jpeg_wr_addr, o_jpeg_wr_data
    );

    modport slave (
        output i_jpeg_byte, i_jpeg_vld, i_jpeg_eof, i_jpeg_wr_down,
        input  o_jpeg_ready, o_jpeg_wr_req, o_jpeg_wr_addr, o_jpeg_wr_data
    );
endinterface

// File: rtl/ddr3_master_wr.sv
// ddr3_master_wr
// Captures one JPEG frame per i_en rising edge: bytes are packed big-endian
// into 128-bit words, queued in a 2-entry word FIFO and written to DDR3 at
// consecutive word addresses starting at BASE_ADDR.
// Ports:
//   i_pclk84m        : sole clock, rising edge
//   i_rst            : synchronous active-high reset
//   i_en             : rising edge arms capture of one frame (IDLE only)
//   bus (master)     : JPEG byte stream in, DDR3 write request/ack
//   o_busy           : FSM not in IDLE
//   o_error          : sticky, a word was dropped because the frame exceeded MAX_WORDS
//   o_frame_done     : one-cycle pulse while in DONE
//   o_addr           : words written in the last frame
//   o_over_byte_len  : valid bytes (1..16) in the last word of the last frame
//   o_total_byte     : length of the last frame in bytes
module ddr3_master_wr #(
    parameter logic [23:0] BASE_ADDR = 24'd0,
    parameter logic [23:0] MAX_WORDS = 24'd65536
) (
    input  logic                    i_pclk84m,
    input  logic                    i_rst,
    input  logic                    i_en,
    ddr3_master_wr_if.master        bus,
    output logic                    o_busy,
    output logic                    o_error,
    output logic                    o_frame_done,
    output logic [23:0]             o_addr,
    output logic [7:0]              o_over_byte_len,
    output logic [24:0]             o_total_byte
);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    localparam logic [24:0] MAX_W = {1'b0, MAX_WORDS};

    state_t         state, state_nxt;
    logic           en_d;
    logic           en_rise;
    logic           start;
    logic           done_entry;
    logic           ready;
    logic           fire;

    logic [127:0]   pack_word;
    logic [3:0]     pack_cnt;
    logic [6:0]     shamt;
    logic [127:0]   merged;
    logic           word_full;
    logic           room;
    logic           push;
    logic           discard;
    logic [24:0]    push_cnt;
    logic [4:0]     last_len;
    logic           error;

    logic [127:0]   fifo_mem [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     fifo_cnt;

    logic           req;
    logic           ack;
    logic [23:0]    wr_addr;
    logic [127:0]   wr_data;
    logic [23:0]    word_cnt;

    logic [23:0]    addr_q;
    logic [7:0]     over_q;
    logic [24:0]    total_q;

    assign en_rise    = i_en & ~en_d;
    assign start      = (state == IDLE) & en_rise;
    assign done_entry = (state == FLUSH) & (state_nxt == DONE);
    assign fire       = bus.i_jpeg_vld & ready;
    assign ack        = req & bus.i_jpeg_wr_down;

    // A word is complete on its 16th byte or on the eof byte (zero-padded).
    assign word_full  = fire & (bus.i_jpeg_eof | (pack_cnt == 4'd15));
    assign room       = push_cnt < MAX_W;
    assign push       = word_full & room;
    assign discard    = word_full & ~room;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_pclk84m) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge detector follows i_en even in reset so a level held across
    // reset is not mistaken for a new edge.
    always_ff @(posedge i_pclk84m) begin
        en_d <= i_en;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_rise) state_nxt = CAPTURE;
            CAPTURE: if (fire && bus.i_jpeg_eof) state_nxt = FLUSH;
            FLUSH:   if ((fifo_cnt == 2'd0) && !req) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready        = (state == CAPTURE) && (fifo_cnt != 2'd2);
        o_busy       = (state != IDLE);
        o_frame_done = (state == DONE);
    end

    // ---------------- byte packer ----------------
    always_comb begin
        shamt  = 7'd120 - {pack_cnt, 3'b000};
        merged = pack_word | ({120'd0, bus.i_jpeg_byte} << shamt);
    end

    always_ff @(posedge i_pclk84m) begin
        if (i_rst || start) begin
            pack_word <= '0;
            pack_cnt  <= '0;
        end else if (fire) begin
            if (word_full) begin
                pack_word <= '0;
                pack_cnt  <= '0;
            end else begin
                pack_word <= merged;
                pack_cnt  <= pack_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_pclk84m) begin
        if (i_rst) begin
            last_len <= '0;
        end else if (fire && bus.i_jpeg_eof) begin
            last_len <= {1'b0, pack_cnt} + 5'd1;
        end
    end

    // push_cnt counts words accepted into the FIFO; it gates overflow.
    always_ff @(posedge i_pclk84m) begin
        if (i_rst || start) begin
            push_cnt <= '0;
            error    <= 1'b0;
        end else begin
            if (push)    push_cnt <= push_cnt + 25'd1;
            if (discard) error    <= 1'b1;
        end
    end

    // ---------------- word FIFO ----------------
    always_ff @(posedge i_pclk84m) begin
        if (push) fifo_mem[wr_ptr] <= merged;
    end

    always_ff @(posedge i_pclk84m) begin
        if (i_rst || start) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (ack)  rd_ptr <= ~rd_ptr;
            case ({push, ack})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- DDR3 write channel ----------------
    // The request drops on the edge that samples the ack, so it is low for
    // at least one cycle before the next head word is presented.
    always_ff @(posedge i_pclk84m) begin
        if (i_rst) begin
            req      <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= '0;
            word_cnt <= '0;
        end else if (start) begin
            wr_addr  <= BASE_ADDR;
            word_cnt <= '0;
        end else if (ack) begin
            req      <= 1'b0;
            wr_addr  <= wr_addr + 24'd1;
            word_cnt <= word_cnt + 24'd1;
        end else if (!req && (fifo_cnt != 2'd0)) begin
            req      <= 1'b1;
            wr_data  <= fifo_mem[rd_ptr];
        end
    end

    // ---------------- frame summary ----------------
    // Loaded on the edge entering DONE so it is valid alongside o_frame_done.
    always_ff @(posedge i_pclk84m) begin
        if (i_rst) begin
            addr_q  <= '0;
            over_q  <= '0;
            total_q <= '0;
        end else if (done_entry) begin
            addr_q  <= word_cnt;
            over_q  <= {3'b000, last_len};
            total_q <= 25'({word_cnt - 24'd1, 4'b0000}) + {20'd0, last_len};
        end
    end

    assign bus.o_jpeg_ready   = ready;
    assign bus.o_jpeg_wr_req  = req;
    assign bus.o_jpeg_wr_addr = wr_addr;
    assign bus.o_jpeg_wr_data = wr_data;
    assign o_error            = error;
    assign o_addr             = addr_q;
    assign o_over_byte_len    = over_q;
    assign o_total_byte       = total_q;

endmodule
